// File: rtl/nd_array_transpose_buffer.sv
// Double-buffered streaming transposer: accepts ROWS row beats, emits COLS column beats.
// Optional frame counter output enabled by defining ND_TRANSPOSE_FRAME_CNT_EN.
module nd_array_transpose_buffer #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int ELEM_W = 8
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [COLS*ELEM_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ROWS*ELEM_W-1:0] out_data,
    output logic                   out_last
`ifdef ND_TRANSPOSE_FRAME_CNT_EN
    ,
    output logic [15:0]            frame_cnt
`endif
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    logic [ELEM_W-1:0] bank_mem [2][ROWS][COLS];

    logic          wr_bank;
    logic          rd_bank;
    logic [RW-1:0] wr_row;
    logic [CW-1:0] rd_col;
    logic [1:0]    full;
    logic [1:0]    full_next;

    logic wr_fire;
    logic rd_fire;
    logic wr_frame_done;
    logic rd_frame_done;

    assign in_ready      = !full[wr_bank];
    assign out_valid     = full[rd_bank];
    assign wr_fire       = in_valid & in_ready;
    assign rd_fire       = out_valid & out_ready;
    assign wr_frame_done = wr_fire && (wr_row == RW'(ROWS - 1));
    assign rd_frame_done = rd_fire && (rd_col == CW'(COLS - 1));
    assign out_last      = out_valid && (rd_col == CW'(COLS - 1));

    // Set and clear never hit the same bank: set needs it empty, clear needs it full.
    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
        full_next = full;
        if (wr_frame_done) full_next[wr_bank] = 1'b1;
        if (rd_frame_done) full_next[rd_bank] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_row  <= '0;
            rd_col  <= '0;
            full    <= '0;
        end else begin
            if (wr_fire)       wr_row  <= wr_frame_done ? '0 : wr_row + 1'b1;
            if (wr_frame_done) wr_bank <= ~wr_bank;
            if (rd_fire)       rd_col  <= rd_frame_done ? '0 : rd_col + 1'b1;
            if (rd_frame_done) rd_bank <= ~rd_bank;
            full <= full_next;
        end
    end

    // NOTE: the banks carry no reset; full[] alone decides whether their contents are meaningful.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int c = 0; c < COLS; c++) begin
                bank_mem[wr_bank][wr_row][c] <= in_data[c*ELEM_W +: ELEM_W];
            end
        end
    end

    // Column rd_col of the read bank, forced to zero while nothing is valid.
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            for (int r = 0; r < ROWS; r++) begin
                out_data[r*ELEM_W +: ELEM_W] = bank_mem[rd_bank][r][rd_col];
            end
        end
    end

`ifdef ND_TRANSPOSE_FRAME_CNT_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            frame_cnt <= '0;
        end else if (rd_frame_done) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_nd_array_transpose_buffer.sv
// Self-checking bench: a 2x3x4 instance driven from a vector table, and a default
// 4x4x8 instance under random handshakes compared against a queue-based transpose model.
module tb_nd_array_transpose_buffer;

    localparam int R = 4;
    localparam int C = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Small instance: 2 rows x 3 cols x 4 bits
    logic        s_rst_n = 1'b0;
    logic        s_in_valid = 1'b0;
    logic        s_in_ready;
    logic [11:0] s_in_data = '0;
    logic        s_out_valid;
    logic        s_out_ready = 1'b0;
    logic [7:0]  s_out_data;
    logic        s_out_last;

    // Default instance
    logic           b_rst_n = 1'b0;
    logic           b_in_valid = 1'b0;
    logic           b_in_ready;
    logic [C*W-1:0] b_in_data = '0;
    logic           b_out_valid;
    logic           b_out_ready = 1'b0;
    logic [R*W-1:0] b_out_data;
    logic           b_out_last;

`ifdef ND_TRANSPOSE_FRAME_CNT_EN
    logic [15:0] s_frame_cnt;
    logic [15:0] b_frame_cnt;
`endif

    nd_array_transpose_buffer #(.ROWS(2), .COLS(3), .ELEM_W(4)) u_small (
        .clk      (clk),
        .arst_n   (s_rst_n),
        .in_valid (s_in_valid),
        .in_ready (s_in_ready),
        .in_data  (s_in_data),
        .out_valid(s_out_valid),
        .out_ready(s_out_ready),
        .out_data (s_out_data),
        .out_last (s_out_last)
`ifdef ND_TRANSPOSE_FRAME_CNT_EN
        ,
        .frame_cnt(s_frame_cnt)
`endif
    );

    nd_array_transpose_buffer #(.ROWS(R), .COLS(C), .ELEM_W(W)) u_big (
        .clk      (clk),
        .arst_n   (b_rst_n),
        .in_valid (b_in_valid),
        .in_ready (b_in_ready),
        .in_data  (b_in_data),
        .out_valid(b_out_valid),
        .out_ready(b_out_ready),
        .out_data (b_out_data),
        .out_last (b_out_last)
`ifdef ND_TRANSPOSE_FRAME_CNT_EN
        ,
        .frame_cnt(b_frame_cnt)
`endif
    );

    // Vector table for the small instance: two rows in, three expected columns out
    typedef struct packed {
        logic [11:0]     row0;
        logic [11:0]     row1;
        logic [2:0][7:0] cols;
    } svec_t;

    svec_t svecs [3];

    // Reference model: rows collect into frames; each full frame yields its columns
    logic [C*W-1:0] row_buf [$];
    logic [R*W-1:0] exp_q [$];
    int             out_beat   = 0;
    int             fed_cnt    = 0;
    int             frames_out = 0;
    logic           stall      = 1'b0;
    logic [R*W-1:0] prev_data  = '0;

    function automatic void model_accept_row(input logic [C*W-1:0] d);
        logic [C*W-1:0] row;
        logic [R*W-1:0] col;
        row_buf.push_back(d);
        if (row_buf.size() == R) begin
            for (int c = 0; c < C; c++) begin
                col = '0;
                for (int r = 0; r < R; r++) begin
                    row = row_buf[r];
                    col[r*W +: W] = row[c*W +: W];
                end
                exp_q.push_back(col);
            end
            row_buf.delete();
        end
    endfunction

    function automatic void model_reset();
        row_buf.delete();
        exp_q.delete();
        out_beat   = 0;
        frames_out = 0;
        stall      = 1'b0;
    endfunction

    // One cycle on the default instance: drive after the edge, observe at the negedge
    task automatic cycle_b(input logic v, input logic [C*W-1:0] d, input logic rdy);
        logic [R*W-1:0] exp_col;
        @(posedge clk);
        #1;
        b_in_valid  = v;
        b_in_data   = d;
        b_out_ready = rdy;
        @(negedge clk);
        if (stall) begin
            check("stall_valid", b_out_valid, 1'b1);
            check("stall_data", b_out_data, prev_data);
        end
        if (v && b_in_ready) begin
            model_accept_row(d);
            fed_cnt++;
        end
        if (b_out_valid && rdy) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", b_out_data, '0);
                check("unexpected_valid", b_out_valid, 1'b0);
            end else begin
                exp_col = exp_q.pop_front();
                check("col_data", b_out_data, exp_col);
                check("col_last", b_out_last, (out_beat == C - 1));
                if (out_beat == C - 1) frames_out++;
                out_beat = (out_beat + 1) % C;
            end
        end
        stall     = b_out_valid && !rdy;
        prev_data = b_out_data;
    endtask

    task automatic run(input int n_rows, input int p_v, input int p_r);
        int start  = fed_cnt;
        int budget = 20 * n_rows + 100;
        logic v;
        logic rdy;
        while (((fed_cnt - start) < n_rows || exp_q.size() != 0) && budget > 0) begin
            v   = ((fed_cnt - start) < n_rows) && ($urandom_range(99) < p_v);
            rdy = ($urandom_range(99) < p_r);
            cycle_b(v, $urandom, rdy);
            budget--;
        end
        check("run_timeout", (budget > 0), 1'b1);
        @(posedge clk);
        #1;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;
        stall       = 1'b0;
        @(negedge clk);
        check("run_drained_valid", b_out_valid, 1'b0);
    endtask

    initial begin
        int acc;

        svecs[0] = '{row0: 12'h210, row1: 12'h543, cols: {8'h52, 8'h41, 8'h30}};
        svecs[1] = '{row0: 12'hFED, row1: 12'h987, cols: {8'h9F, 8'h8E, 8'h7D}};
        svecs[2] = '{row0: 12'hA5C, row1: 12'h01F, cols: {8'h0A, 8'h15, 8'hFC}};

        repeat (3) @(posedge clk);
        #1;
        s_rst_n = 1'b1;
        b_rst_n = 1'b1;

        // Reset state, out_ready high with both banks empty must be ignored
        s_out_ready = 1'b1;
        @(negedge clk);
        check("rst_in_ready", s_in_ready, 1'b1);
        check("rst_out_valid", s_out_valid, 1'b0);
        check("rst_out_data", s_out_data, 8'h00);
        check("rst_out_last", s_out_last, 1'b0);
        check("rst_b_in_ready", b_in_ready, 1'b1);
        check("rst_b_out_valid", b_out_valid, 1'b0);

        // Table-driven small frames; alternates banks 0,1,0
        for (int v = 0; v < 3; v++) begin
            @(posedge clk);
            #1;
            s_in_valid = 1'b1;
            s_in_data  = svecs[v].row0;
            @(negedge clk);
            check("s_in_ready_r0", s_in_ready, 1'b1);
            check("s_no_valid_r0", s_out_valid, 1'b0);
            @(posedge clk);
            #1;
            s_in_data = svecs[v].row1;
            @(negedge clk);
            check("s_in_ready_r1", s_in_ready, 1'b1);
            check("s_no_valid_r1", s_out_valid, 1'b0);
            @(posedge clk);
            #1;
            s_in_valid = 1'b0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                check("s_out_valid", s_out_valid, 1'b1);
                check("s_out_data", s_out_data, svecs[v].cols[c]);
                check("s_out_last", s_out_last, (c == 2));
                check("s_in_ready", s_in_ready, 1'b1);
                @(posedge clk);
            end
            @(negedge clk);
            check("s_drained_valid", s_out_valid, 1'b0);
            check("s_drained_data", s_out_data, 8'h00);
        end
`ifdef ND_TRANSPOSE_FRAME_CNT_EN
        check("s_frame_cnt", s_frame_cnt, 16'd3);
`endif

        // Three frames with the consumer stalled: only two banks' worth accepted
        acc = fed_cnt;
        for (int i = 0; i < 20; i++) begin
            cycle_b(1'b1, $urandom, 1'b0);
            if (!b_in_ready) break;
        end
        check("bp_accepted", fed_cnt - acc, 8);
        check("bp_in_ready", b_in_ready, 1'b0);
        check("bp_out_valid", b_out_valid, 1'b1);
        run(4, 100, 100);
        check("bp_frames", frames_out, 3);

        // Reset while one frame drains and another is half written
        for (int i = 0; i < 4; i++) cycle_b(1'b1, $urandom, 1'b0);
        cycle_b(1'b1, $urandom, 1'b1);
        cycle_b(1'b1, $urandom, 1'b1);
        @(posedge clk);
        #1;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;
        #2;
        b_rst_n = 1'b0;
        #1;
        check("arst_out_valid", b_out_valid, 1'b0);
        check("arst_in_ready", b_in_ready, 1'b1);
        check("arst_out_last", b_out_last, 1'b0);
        check("arst_out_data", b_out_data, '0);
        model_reset();
        @(negedge clk);
        b_rst_n = 1'b1;
        run(4, 100, 100);
        check("post_rst_frames", frames_out, 1);

        // Random handshakes over 200 frames
        model_reset();
        run(200 * R, 50, 50);
        check("rand_frames", frames_out, 200);
`ifdef ND_TRANSPOSE_FRAME_CNT_EN
        check("b_frame_cnt", b_frame_cnt, 16'(frames_out + 1));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nd_array_transpose_buffer.md
Name: nd_array_transpose_buffer

Overview:
- Streaming, double-buffered transposer for a ROWS x COLS array of ELEM_W-bit elements.
- Input accepts one row per beat (COLS elements); output emits one column per beat (ROWS elements).
- Successor to the combinational nd-array index/permute blocks emitted by the Verilog backend: parametrised shape, registered storage, valid/ready handshake on both sides.
- Sits between array-producing and array-consuming pipeline stages.

Parameters:
- ROWS, 4, rows per frame (>=2).
- COLS, 4, columns per frame (>=2).
- ELEM_W, 8, element width in bits (>=1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- arst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  row beat valid.
- in_ready  out  1  row beat accepted when in_valid & in_ready.
- in_data  in  COLS*ELEM_W  row; element c at bits [c*ELEM_W +: ELEM_W].
- out_valid  out  1  column beat valid.
- out_ready  in  1  column beat consumed when out_valid & out_ready.
- out_data  out  ROWS*ELEM_W  column c; element r at bits [r*ELEM_W +: ELEM_W] = A[r][c].
- out_last  out  1  high with the final column (c = COLS-1) of a frame.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. arst_n low forces wr_bank=0, rd_bank=0, wr_row=0, rd_col=0 and full[1:0]=0. in_ready therefore reads 1 after reset; out_valid=0, out_last=0, out_data=0. Bank contents are not reset.
- Storage: two banks, each ROWS*COLS*ELEM_W flops.
- Write side:
  - in_ready = !full[wr_bank].
  - Each accepted beat writes row wr_row of bank wr_bank.
  - wr_row increments and wraps ROWS-1 -> 0.
  - On the beat with wr_row==ROWS-1: set full[wr_bank] and toggle wr_bank.
- Read side:
  - out_valid = full[rd_bank].
  - out_data = column rd_col of bank rd_bank. It is driven combinationally from registered storage and is 0 when !out_valid.
  - out_last = out_valid & (rd_col==COLS-1).
  - Each accepted beat increments rd_col, which wraps COLS-1 -> 0.
  - On the last column: clear full[rd_bank] and toggle rd_bank.
- Latency: first column of a frame is valid the cycle after the last row's accepting edge.
- Throughput:
  - One beat per cycle on each side.
  - With ROWS==COLS and out_ready held high, both sides stream continuously with no bubbles.
  - Otherwise the slower side back-pressures through full[].
- Simultaneous events:
  - Set and clear of full[] in the same cycle always target different banks (set requires !full, clear requires full), so both take effect.
  - Completing a read of bank b frees b for a write starting the next cycle; there is no same-cycle bypass.
- Both banks full: in_ready=0. Incoming data is held upstream and nothing is overwritten.
- Both empty: out_valid=0. out_ready is ignored.
- Stability: out_data and out_valid stay stable while out_valid & !out_ready.
- Reset mid-frame: a partial frame is discarded and any full frames are lost. The first beat after release is row 0 of bank 0.

Optional Feature:
- Macro: ND_TRANSPOSE_FRAME_CNT_EN.
- Defined: adds output port frame_cnt (16 bits).
  - Increments on each accepted out_last beat.
  - Wraps 0xFFFF -> 0x0000.
  - Reset to 0 by arst_n.
- Undefined: the port and its counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset release, ROWS=2 COLS=3 ELEM_W=4, no stimulus -> in_ready=1, out_valid=0, out_data=0, out_last=0.
- Same shape; rows in_data=0x210 then 0x543, out_ready=1 -> one cycle later, consecutive beats out_data=0x30, 0x41, 0x52; out_last high only on 0x52; in_ready stays 1 throughout.
- Defaults (4x4x8); stream 3 frames back-to-back with out_ready=0 -> in_ready drops after 8 accepted beats. Then release out_ready=1 -> frames emerge in order, correctly transposed, with no lost or duplicated beats.
- Defaults; random in_valid/out_ready (50%) over 200 frames vs reference transpose model -> zero mismatches. out_data is stable whenever out_valid & !out_ready.
- Defaults; assert arst_n low after 2 rows of a frame while another frame is mid-drain -> out_valid=0 and in_ready=1 immediately (asynchronously). The next full frame after release transposes correctly.
- Macro defined; 65537 frames -> frame_cnt reads 0x0001 after the last out_last beat. With macro undefined, the build has no frame_cnt port.
